// File: rtl/song_menu_fsm_if.sv
// Bundle of menu-side signals between the game FSM / button front end and the song menu.
// master drives the control inputs and observes the menu outputs; slave is the menu itself.
interface song_menu_fsm_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned BPM_W = 16
);
    logic             enable;
    logic             btn_left;
    logic             btn_right;
    logic             btn_select;
    logic             start_ack;
    logic [IDX_W-1:0] selected_song;
    logic [BPM_W-1:0] bpm_output;
    logic             popup_valid;
    logic             start_req;
    logic             busy;

    modport master (
        output enable,
        output btn_left,
        output btn_right,
        output btn_select,
        output start_ack,
        input  selected_song,
        input  bpm_output,
        input  popup_valid,
        input  start_req,
        input  busy
    );

    modport slave (
        input  enable,
        input  btn_left,
        input  btn_right,
        input  btn_select,
        input  start_ack,
        output selected_song,
        output bpm_output,
        output popup_valid,
        output start_req,
        output busy
    );
endinterface

// File: rtl/song_menu_fsm.sv
// Song-selection menu: left/right browsing with wrap or saturation, hold-to-repeat stepping,
// a popup strobe retriggered by every step, and a start_req/start_ack handshake that hands
// the chosen song to the game FSM. All outputs are registered.
module song_menu_fsm #(
    parameter int unsigned                   NUM_SONGS    = 3,
    parameter int unsigned                   IDX_W        = 4,
    parameter int unsigned                   BPM_W        = 16,
    parameter logic [NUM_SONGS*BPM_W-1:0]    BPM_TABLE    = {16'd160, 16'd140, 16'd120},
    parameter bit                            WRAP         = 1'b0,
    parameter int unsigned                   REPEAT_DELAY = 25_000_000,
    parameter int unsigned                   REPEAT_RATE  = 5_000_000,
    parameter int unsigned                   POPUP_CYCLES = 100_000_000
) (
    input logic            clk,
    input logic            rst,
    song_menu_fsm_if.slave bus
);

    // The hold counter only ever has to reach the larger of the two repeat intervals.
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W   = $clog2(POPUP_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SONGS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DELAY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] CNT_RATE  = CNT_W'(REPEAT_RATE);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(POPUP_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StBrowse,
        StConfirm,
        StPlaying
    } state_e;

    // BPM lookup with constant slice bases so every table entry is a plain wire select.
    function automatic logic [BPM_W-1:0] bpm_of(input logic [IDX_W-1:0] idx);
        logic [BPM_W-1:0] val;
        val = BPM_TABLE[BPM_W-1:0];
        for (int k = 0; k < int'(NUM_SONGS); k++) begin
            if (idx == IDX_W'(k)) begin
                val = BPM_TABLE[k*BPM_W +: BPM_W];
            end
        end
        return val;
    endfunction

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [BPM_W-1:0] bpm_q;
    logic             popup_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rep_q;     // hold counter has passed the first delay, now pacing at RATE
    logic             left_q;
    logic             right_q;
    logic             select_q;
    logic             start_req_q;
    logic             busy_q;

    logic             left_edge;
    logic             right_edge;
    logic             select_edge;
    logic             one_left;
    logic             one_right;
    logic             press;
    logic             rep_hit;
    logic             in_browse;
    logic             step_left;
    logic             step_right;
    logic             step;
    logic [IDX_W-1:0] idx_next;

    // Decode button edges, hold-repeat hits and the resulting next index.
    always_comb begin
        left_edge   = bus.btn_left & ~left_q;
        right_edge  = bus.btn_right & ~right_q;
        select_edge = bus.btn_select & ~select_q;
        one_left    = bus.btn_left & ~bus.btn_right;
        one_right   = bus.btn_right & ~bus.btn_left;
        press       = (one_left & left_edge) | (one_right & right_edge);
        // cnt_q == 0 means no press edge was seen for the button now held; never repeat then.
        rep_hit     = (cnt_q != '0) && (rep_q ? (cnt_q == CNT_RATE) : (cnt_q == CNT_DELAY));
        in_browse   = (state_q == StBrowse) & bus.enable;
        step_left   = in_browse & one_left & (left_edge | rep_hit);
        step_right  = in_browse & one_right & (right_edge | rep_hit);
        step        = step_left | step_right;

        idx_next = idx_q;
        if (step_left) begin
            if (idx_q == '0) begin
                idx_next = WRAP ? LAST_IDX : '0;
            end else begin
                idx_next = idx_q - IDX_ONE;
            end
        end else if (step_right) begin
            if (idx_q == LAST_IDX) begin
                idx_next = WRAP ? '0 : LAST_IDX;
            end else begin
                idx_next = idx_q + IDX_ONE;
            end
        end
    end

    // Menu state machine with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            bpm_q       <= BPM_TABLE[BPM_W-1:0];
            popup_q     <= 1'b0;
            timer_q     <= '0;
            cnt_q       <= '0;
            rep_q       <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            select_q    <= 1'b0;
            start_req_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            left_q   <= bus.btn_left;
            right_q  <= bus.btn_right;
            select_q <= bus.btn_select;

            if (!bus.enable) begin
                // Selection and BPM are kept so the menu reopens on the last song.
                state_q     <= StIdle;
                start_req_q <= 1'b0;
                busy_q      <= 1'b0;
                timer_q     <= '0;
                popup_q     <= 1'b0;
                cnt_q       <= '0;
                rep_q       <= 1'b0;
            end else begin
                // Every step, even a saturated one, retriggers the popup.
                if (step) begin
                    timer_q <= TMR_LOAD;
                    popup_q <= 1'b1;
                end else if (timer_q != '0) begin
                    timer_q <= timer_q - TMR_ONE;
                    popup_q <= (timer_q != TMR_ONE);
                end

                idx_q <= idx_next;
                bpm_q <= bpm_of(idx_next);

                unique case (state_q)
                    StIdle: begin
                        state_q <= StBrowse;
                        cnt_q   <= '0;
                        rep_q   <= 1'b0;
                    end
                    StBrowse: begin
                        if (!one_left && !one_right) begin
                            cnt_q <= '0;
                            rep_q <= 1'b0;
                        end else if (press) begin
                            cnt_q <= CNT_ONE;
                            rep_q <= 1'b0;
                        end else if (rep_hit) begin
                            cnt_q <= CNT_ONE;
                            rep_q <= 1'b1;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                        // A move in the same cycle takes precedence over select.
                        if (!step && select_edge) begin
                            state_q     <= StConfirm;
                            start_req_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    StConfirm: begin
                        cnt_q <= '0;
                        rep_q <= 1'b0;
                        if (bus.start_ack) begin
                            state_q     <= StPlaying;
                            start_req_q <= 1'b0;
                        end
                    end
                    StPlaying: begin
                        cnt_q <= '0;
                        rep_q <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.selected_song = idx_q;
    assign bus.bpm_output    = bpm_q;
    assign bus.popup_valid   = popup_q;
    assign bus.start_req     = start_req_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_song_menu_fsm.sv
// Bench for song_menu_fsm: three menus (3 songs saturating, 3 songs wrapping, 8 songs
// saturating) share one stimulus stream and are each compared with a cycle-level reference.
module tb_song_menu_fsm;

    localparam int RD = 10;
    localparam int RR = 4;
    localparam int PC = 8;

    localparam int M_IDLE    = 0;
    localparam int M_BROWSE  = 1;
    localparam int M_CONFIRM = 2;
    localparam int M_PLAYING = 3;

    logic clk = 1'b0;
    logic rst;
    logic enable, btn_l, btn_r, btn_s, ack;

    always #5 clk = ~clk;

    song_menu_fsm_if #(.IDX_W(4), .BPM_W(16)) if_a ();
    song_menu_fsm_if #(.IDX_W(4), .BPM_W(16)) if_b ();
    song_menu_fsm_if #(.IDX_W(4), .BPM_W(16)) if_c ();

    assign if_a.enable = enable;  assign if_a.btn_left = btn_l;  assign if_a.btn_right = btn_r;
    assign if_a.btn_select = btn_s;  assign if_a.start_ack = ack;
    assign if_b.enable = enable;  assign if_b.btn_left = btn_l;  assign if_b.btn_right = btn_r;
    assign if_b.btn_select = btn_s;  assign if_b.start_ack = ack;
    assign if_c.enable = enable;  assign if_c.btn_left = btn_l;  assign if_c.btn_right = btn_r;
    assign if_c.btn_select = btn_s;  assign if_c.start_ack = ack;

    song_menu_fsm #(
        .NUM_SONGS(3), .IDX_W(4), .BPM_W(16), .BPM_TABLE({16'd160, 16'd140, 16'd120}),
        .WRAP(1'b0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .POPUP_CYCLES(PC)
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a));

    song_menu_fsm #(
        .NUM_SONGS(3), .IDX_W(4), .BPM_W(16), .BPM_TABLE({16'd160, 16'd140, 16'd120}),
        .WRAP(1'b1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .POPUP_CYCLES(PC)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    song_menu_fsm #(
        .NUM_SONGS(8), .IDX_W(4), .BPM_W(16),
        .BPM_TABLE({16'd170, 16'd160, 16'd150, 16'd140, 16'd130, 16'd120, 16'd110, 16'd100}),
        .WRAP(1'b0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .POPUP_CYCLES(PC)
    ) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    int total = 0;
    int bad   = 0;

    // Reference model: per menu, mode, index, popup cycles left and how long the current
    // single button has been held since its press (-1 when not counting).
    int n_songs [3] = '{3, 3, 8};
    int wraps   [3] = '{0, 1, 0};
    int tbl     [3][8];
    int m_mode  [3];
    int m_idx   [3];
    int m_pop   [3];
    int m_held  [3];
    bit m_pl, m_pr, m_ps;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_mode[d] = M_IDLE;
            m_idx[d]  = 0;
            m_pop[d]  = 0;
            m_held[d] = -1;
        end
        m_pl = 1'b0;
        m_pr = 1'b0;
        m_ps = 1'b0;
    endtask

    // One clock edge worth of menu behaviour, derived from the menu rules directly.
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            bit stepped;
            int dir;
            bit was;
            stepped = 1'b0;
            dir     = 0;
            if (!enable) begin
                m_mode[d] = M_IDLE;
                m_pop[d]  = 0;
                m_held[d] = -1;
            end else begin
                if (m_pop[d] > 0) m_pop[d]--;
                case (m_mode[d])
                    M_IDLE: begin
                        m_mode[d] = M_BROWSE;
                        m_held[d] = -1;
                    end
                    M_BROWSE: begin
                        if (btn_l == btn_r) begin
                            m_held[d] = -1;
                        end else begin
                            was = btn_l ? m_pl : m_pr;
                            if (!was) m_held[d] = 0;
                            else if (m_held[d] >= 0) m_held[d]++;
                            if (m_held[d] == 0 ||
                                (m_held[d] >= RD && (m_held[d] - RD) % RR == 0)) begin
                                stepped = 1'b1;
                                dir     = btn_l ? -1 : 1;
                            end
                        end
                        if (stepped) begin
                            m_idx[d] = m_idx[d] + dir;
                            if (m_idx[d] < 0) m_idx[d] = wraps[d] ? n_songs[d] - 1 : 0;
                            if (m_idx[d] >= n_songs[d]) m_idx[d] = wraps[d] ? 0 : n_songs[d] - 1;
                            m_pop[d] = PC;
                        end else if (btn_s && !m_ps) begin
                            m_mode[d] = M_CONFIRM;
                        end
                    end
                    M_CONFIRM: begin
                        m_held[d] = -1;
                        if (ack) m_mode[d] = M_PLAYING;
                    end
                    default: m_held[d] = -1;
                endcase
            end
        end
        m_pl = btn_l;
        m_pr = btn_r;
        m_ps = btn_s;
    endtask

    task automatic check_dut(input int d, input int idx, input int bpm, input int pop,
                             input int req, input int bsy);
        string p;
        p = $sformatf("dut%0d", d);
        check({p, ".idx"}, idx, m_idx[d]);
        check({p, ".bpm"}, bpm, tbl[d][m_idx[d]]);
        check({p, ".popup"}, pop, (m_pop[d] != 0) ? 1 : 0);
        check({p, ".start_req"}, req, (m_mode[d] == M_CONFIRM) ? 1 : 0);
        check({p, ".busy"}, bsy, (m_mode[d] >= M_CONFIRM) ? 1 : 0);
    endtask

    task automatic check_all();
        check_dut(0, int'(if_a.selected_song), int'(if_a.bpm_output), int'(if_a.popup_valid),
                  int'(if_a.start_req), int'(if_a.busy));
        check_dut(1, int'(if_b.selected_song), int'(if_b.bpm_output), int'(if_b.popup_valid),
                  int'(if_b.start_req), int'(if_b.busy));
        check_dut(2, int'(if_c.selected_song), int'(if_c.bpm_output), int'(if_c.popup_valid),
                  int'(if_c.start_req), int'(if_c.busy));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        btn_l  = 1'b0;
        btn_r  = 1'b0;
        btn_s  = 1'b0;
        ack    = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int en, l, r, s, ack;
        int ia, ba, ib, bb, req, busy;
    } vec_t;

    vec_t vecs [26];

    initial begin
        int n;
        for (int k = 0; k < 8; k++) begin
            tbl[0][k] = (k < 3) ? 120 + 20 * k : 0;
            tbl[1][k] = (k < 3) ? 120 + 20 * k : 0;
            tbl[2][k] = 100 + 10 * k;
        end

        //          en l  r  s  ack  a_idx a_bpm b_idx b_bpm req busy
        vecs[0]  = '{1, 0, 0, 0, 0,  0, 120, 0, 120, 0, 0};
        vecs[1]  = '{1, 0, 1, 0, 0,  1, 140, 1, 140, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0,  1, 140, 1, 140, 0, 0};
        vecs[3]  = '{1, 0, 1, 0, 0,  2, 160, 2, 160, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0,  2, 160, 2, 160, 0, 0};
        vecs[5]  = '{1, 0, 1, 0, 0,  2, 160, 0, 120, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 0,  2, 160, 0, 120, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 0,  1, 140, 2, 160, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 0,  1, 140, 2, 160, 0, 0};
        vecs[9]  = '{1, 1, 0, 0, 0,  0, 120, 1, 140, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 0,  0, 120, 1, 140, 0, 0};
        vecs[11] = '{1, 1, 0, 0, 0,  0, 120, 0, 120, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 0,  0, 120, 0, 120, 0, 0};
        vecs[13] = '{1, 1, 0, 0, 0,  0, 120, 2, 160, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 0,  0, 120, 2, 160, 0, 0};
        vecs[15] = '{1, 1, 1, 0, 0,  0, 120, 2, 160, 0, 0};
        vecs[16] = '{1, 0, 0, 0, 0,  0, 120, 2, 160, 0, 0};
        vecs[17] = '{1, 0, 0, 1, 0,  0, 120, 2, 160, 1, 1};
        vecs[18] = '{1, 0, 1, 0, 0,  0, 120, 2, 160, 1, 1};
        vecs[19] = '{1, 0, 0, 0, 0,  0, 120, 2, 160, 1, 1};
        vecs[20] = '{1, 0, 0, 0, 0,  0, 120, 2, 160, 1, 1};
        vecs[21] = '{1, 0, 0, 0, 0,  0, 120, 2, 160, 1, 1};
        vecs[22] = '{1, 0, 0, 0, 1,  0, 120, 2, 160, 0, 1};
        vecs[23] = '{1, 0, 1, 0, 0,  0, 120, 2, 160, 0, 1};
        vecs[24] = '{1, 0, 0, 0, 0,  0, 120, 2, 160, 0, 1};
        vecs[25] = '{0, 0, 0, 0, 0,  0, 120, 2, 160, 0, 0};

        do_reset();
        check("reset.a_idx", int'(if_a.selected_song), 0);
        check("reset.a_bpm", int'(if_a.bpm_output), 120);
        check("reset.c_bpm", int'(if_c.bpm_output), 100);
        check("reset.a_popup", int'(if_a.popup_valid), 0);
        check("reset.a_req", int'(if_a.start_req), 0);
        check("reset.a_busy", int'(if_a.busy), 0);

        // Browse, saturate/wrap, select, handshake and disable from a stimulus table.
        for (int i = 0; i < 26; i++) begin
            enable = (vecs[i].en != 0);
            btn_l  = (vecs[i].l != 0);
            btn_r  = (vecs[i].r != 0);
            btn_s  = (vecs[i].s != 0);
            ack    = (vecs[i].ack != 0);
            tick();
            check($sformatf("vec%0d.a_idx", i), int'(if_a.selected_song), vecs[i].ia);
            check($sformatf("vec%0d.a_bpm", i), int'(if_a.bpm_output), vecs[i].ba);
            check($sformatf("vec%0d.b_idx", i), int'(if_b.selected_song), vecs[i].ib);
            check($sformatf("vec%0d.b_bpm", i), int'(if_b.bpm_output), vecs[i].bb);
            check($sformatf("vec%0d.req", i), int'(if_a.start_req), vecs[i].req);
            check($sformatf("vec%0d.busy", i), int'(if_a.busy), vecs[i].busy);
        end

        // Popup length after a single move, then a left+right press that must not step.
        do_reset();
        enable = 1'b1;
        tick();
        btn_r = 1'b1;
        tick();
        btn_r = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!if_a.popup_valid) break;
            n++;
            tick();
        end
        check("popup.len", n, PC);
        btn_l = 1'b1;
        btn_r = 1'b1;
        tick();
        check("both.idx", int'(if_a.selected_song), 1);
        check("both.popup", int'(if_a.popup_valid), 0);
        btn_l = 1'b0;
        btn_r = 1'b0;
        tick();

        // Hold right 20 cycles on the 8-song menu: steps at press, 10, 14 and 18.
        do_reset();
        enable = 1'b1;
        tick();
        btn_r = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            check($sformatf("hold.t%0d", t), int'(if_c.selected_song),
                  (t < 10) ? 1 : (t < 14) ? 2 : (t < 18) ? 3 : 4);
        end
        btn_r = 1'b0;
        tick();
        check("hold.final_idx", int'(if_c.selected_song), 4);
        check("hold.final_bpm", int'(if_c.bpm_output), 140);
        check("hold.sat_idx", int'(if_a.selected_song), 2);

        // Asynchronous reset while waiting for start_ack.
        do_reset();
        enable = 1'b1;
        tick();
        btn_r = 1'b1;
        tick();
        btn_r = 1'b0;
        tick();
        btn_s = 1'b1;
        tick();
        btn_s = 1'b0;
        check("rstc.req_before", int'(if_a.start_req), 1);
        rst = 1'b1;
        #1;
        check("rstc.req", int'(if_a.start_req), 0);
        check("rstc.idx", int'(if_a.selected_song), 0);
        check("rstc.bpm", int'(if_a.bpm_output), 120);
        check("rstc.busy", int'(if_a.busy), 0);
        check("rstc.popup", int'(if_a.popup_valid), 0);
        do_reset();

        // Randomised sessions with persistent button holds and occasional resets.
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 11) == 0) btn_l = ~btn_l;
            if ($urandom_range(0, 11) == 0) btn_r = ~btn_r;
            btn_s = ($urandom_range(0, 19) == 0);
            ack   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
